// File: rtl/y86_pkg.sv
// Shared definitions for the sequential Y86-64 core:
// icodes, status codes, sequencer states and icode classifiers.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // One-hot stage vector, bit order {P,W,M,E,D,F}
    localparam logic [5:0] STG_NONE = 6'b000000;
    localparam logic [5:0] STG_F    = 6'b000001;
    localparam logic [5:0] STG_D    = 6'b000010;
    localparam logic [5:0] STG_E    = 6'b000100;
    localparam logic [5:0] STG_M    = 6'b001000;
    localparam logic [5:0] STG_W    = 6'b010000;
    localparam logic [5:0] STG_P    = 6'b100000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_PCUPD,
        S_HALT,
        S_ERROR
    } state_t;

    function automatic logic needs_mem(input logic [3:0] ic);
        case (ic)
            I_RMMOV, I_MRMOV, I_CALL,
            I_RET, I_PUSH, I_POP: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic mem_is_write(input logic [3:0] ic);
        case (ic)
            I_RMMOV, I_CALL, I_PUSH: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic writes_vale(
        input logic [3:0] ic,
        input logic       c
    );
        case (ic)
            I_IRMOV, I_OPQ, I_CALL,
            I_RET, I_PUSH, I_POP: return 1'b1;
            I_CMOV:               return c;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic writes_valm(input logic [3:0] ic);
        case (ic)
            I_MRMOV, I_POP: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_perf_cnt.sv
// Active-cycle and retired-instruction counters for the Y86-64 sequencer.
// Both wrap modulo 2^CNT_W.
module y86_perf_cnt
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_busy,
    input  logic             i_retire,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_retired_cnt
);

    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle   <= '0;
            r_retired <= '0;
        end else begin
            if (i_busy) begin
                r_cycle <= r_cycle + CNT_W'(1);
            end
            if (i_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign o_cycle_cnt   = r_cycle;
    assign o_retired_cnt = r_retired;

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle F/D/E/M/W/P stage sequencer for the sequential Y86-64 core.
// Performance counters are built only when Y86_SEQ_CTRL_PERF_EN is defined.
module y86_seq_ctrl
    import y86_pkg::*;
#(
    parameter int STAT_W = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic              instr_valid,
    input  logic              imem_error,
    input  logic              cnd,
    input  logic              mem_ready,
    input  logic              dmem_error,
    output logic [5:0]        stage,
    output logic              mem_req,
    output logic              mem_wr,
    output logic              cc_we,
    output logic              rf_we_e,
    output logic              rf_we_m,
    output logic              pc_we,
    output logic [STAT_W-1:0] stat,
    output logic              busy,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam logic [STAT_W-1:0] W_AOK = STAT_W'(STAT_AOK);
    localparam logic [STAT_W-1:0] W_HLT = STAT_W'(STAT_HLT);
    localparam logic [STAT_W-1:0] W_ADR = STAT_W'(STAT_ADR);
    localparam logic [STAT_W-1:0] W_INS = STAT_W'(STAT_INS);

    state_t            r_state;
    logic [3:0]        r_icode;
    logic              r_cnd;
    logic [STAT_W-1:0] r_stat;
    logic [5:0]        r_stage;
    logic              r_mem_req;
    logic              r_mem_wr;
    logic              r_cc_we;
    logic              r_rf_we_e;
    logic              r_rf_we_m;
    logic              r_pc_we;
    logic              r_busy;

    // Outputs are computed for the state being entered, so each strobe
    // is high exactly while the FSM sits in its owning state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_icode   <= I_HALT;
            r_cnd     <= 1'b0;
            r_stat    <= W_AOK;
            r_stage   <= STG_NONE;
            r_mem_req <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_cc_we   <= 1'b0;
            r_rf_we_e <= 1'b0;
            r_rf_we_m <= 1'b0;
            r_pc_we   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_cc_we   <= 1'b0;
            r_rf_we_e <= 1'b0;
            r_rf_we_m <= 1'b0;
            r_pc_we   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_stage <= STG_F;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_icode <= icode;
                    if (imem_error) begin
                        r_state <= S_ERROR;
                        r_stat  <= W_ADR;
                        r_stage <= STG_NONE;
                        r_busy  <= 1'b0;
                    end else if (!instr_valid) begin
                        r_state <= S_ERROR;
                        r_stat  <= W_INS;
                        r_stage <= STG_NONE;
                        r_busy  <= 1'b0;
                    end else if (icode == I_HALT) begin
                        r_state <= S_HALT;
                        r_stat  <= W_HLT;
                        r_stage <= STG_NONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_DECODE;
                        r_stage <= STG_D;
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                    r_stage <= STG_E;
                    r_cc_we <= (r_icode == I_OPQ);
                end
                S_EXEC: begin
                    r_cnd <= cnd;
                    if (needs_mem(r_icode)) begin
                        r_state   <= S_MEM;
                        r_stage   <= STG_M;
                        r_mem_req <= 1'b1;
                        r_mem_wr  <= mem_is_write(r_icode);
                    end else begin
                        // cnd is used live: cnd_q only lands on this edge
                        r_state   <= S_WB;
                        r_stage   <= STG_W;
                        r_rf_we_e <= writes_vale(r_icode, cnd);
                        r_rf_we_m <= writes_valm(r_icode);
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_wr  <= 1'b0;
                        if (dmem_error) begin
                            r_state <= S_ERROR;
                            r_stat  <= W_ADR;
                            r_stage <= STG_NONE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= S_WB;
                            r_stage   <= STG_W;
                            r_rf_we_e <= writes_vale(r_icode, r_cnd);
                            r_rf_we_m <= writes_valm(r_icode);
                        end
                    end
                end
                S_WB: begin
                    r_state <= S_PCUPD;
                    r_stage <= STG_P;
                    r_pc_we <= 1'b1;
                end
                S_PCUPD: begin
                    r_state <= S_FETCH;
                    r_stage <= STG_F;
                end
                S_HALT, S_ERROR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stage <= STG_NONE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign stage   = r_stage;
    assign mem_req = r_mem_req;
    assign mem_wr  = r_mem_wr;
    assign cc_we   = r_cc_we;
    assign rf_we_e = r_rf_we_e;
    assign rf_we_m = r_rf_we_m;
    assign pc_we   = r_pc_we;
    assign stat    = r_stat;
    assign busy    = r_busy;

`ifdef Y86_SEQ_CTRL_PERF_EN
    y86_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .i_busy       (r_busy),
        .i_retire     (r_pc_we),
        .o_cycle_cnt  (cycle_cnt),
        .o_retired_cnt(retired_cnt)
    );
`else
    assign cycle_cnt   = '0;
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Randomized bench for y86_seq_ctrl with a per-instruction trace model.
// Counter expectations follow Y86_SEQ_CTRL_PERF_EN.
module tb_y86_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic        cnd;
    logic        mem_ready;
    logic        dmem_error;
    logic [5:0]  stage;
    logic        mem_req;
    logic        mem_wr;
    logic        cc_we;
    logic        rf_we_e;
    logic        rf_we_m;
    logic        pc_we;
    logic [2:0]  stat;
    logic        busy;
    logic [31:0] cycle_cnt;
    logic [31:0] retired_cnt;

    always #5 clk = ~clk;

    y86_seq_ctrl #(
        .STAT_W(3),
        .CNT_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .icode      (icode),
        .instr_valid(instr_valid),
        .imem_error (imem_error),
        .cnd        (cnd),
        .mem_ready  (mem_ready),
        .dmem_error (dmem_error),
        .stage      (stage),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .cc_we      (cc_we),
        .rf_we_e    (rf_we_e),
        .rf_we_m    (rf_we_m),
        .pc_we      (pc_we),
        .stat       (stat),
        .busy       (busy),
        .cycle_cnt  (cycle_cnt),
        .retired_cnt(retired_cnt)
    );

    localparam logic [5:0] SN = 6'b000000;
    localparam logic [5:0] SF = 6'b000001;
    localparam logic [5:0] SD = 6'b000010;
    localparam logic [5:0] SE = 6'b000100;
    localparam logic [5:0] SM = 6'b001000;
    localparam logic [5:0] SW = 6'b010000;
    localparam logic [5:0] SP = 6'b100000;

    typedef struct packed {
        logic [5:0]  stg;
        logic        req;
        logic        wr;
        logic        cc;
        logic        rfe;
        logic        rfm;
        logic        pcw;
        logic [2:0]  st;
        logic        bsy;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t        expq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned m_cyc = 0;
    int unsigned m_ret = 0;

    int mon_pc = 0, mon_rfe = 0, mon_rfm = 0, mon_both = 0;
    int mon_req = 0, mon_busy = 0, mon_w = 0;

    // Cycle-by-cycle comparison against the model trace
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = '{stage, mem_req, mem_wr, cc_we, rf_we_e, rf_we_m,
                  pc_we, stat, busy, cycle_cnt, retired_cnt};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL trace t=%0t got=%h expected=%h",
                         $time, a, e);
            end
        end
    end

    always @(negedge clk) begin
        if (pc_we)              mon_pc++;
        if (rf_we_e)            mon_rfe++;
        if (rf_we_m)            mon_rfm++;
        if (rf_we_e && rf_we_m) mon_both++;
        if (mem_req)            mon_req++;
        if (busy)               mon_busy++;
        if (stage[4])           mon_w++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] s, input logic [2:0] st);
        exp_t e;
        e     = '0;
        e.stg = s;
        e.st  = st;
        e.bsy = (s != SN);
        return e;
    endfunction

    task automatic push(input exp_t e);
`ifdef Y86_SEQ_CTRL_PERF_EN
        e.cyc = m_cyc;
        e.ret = m_ret;
`endif
        expq.push_back(e);
        if (e.bsy) m_cyc++;
        if (e.pcw) m_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        start       = 1'($urandom);
        icode       = 4'($urandom);
        instr_valid = 1'($urandom);
        imem_error  = 1'($urandom);
        cnd         = 1'($urandom);
        mem_ready   = 1'($urandom);
        dmem_error  = 1'($urandom);
    endtask

    task automatic release_reset();
        rand_in();
        rst   = 1'b0;
        start = 1'b0;
        push(mk(SN, 3'd1));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        m_cyc = 0;
        m_ret = 0;
        rand_in();
        push(mk(SN, 3'd1));
        rand_in();
        push(mk(SN, 3'd1));
        release_reset();
    endtask

    task automatic begin_run();
        int k;
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) begin
            rand_in();
            start = 1'b0;
            push(mk(SN, 3'd1));
        end
        rand_in();
        start = 1'b1;
        push(mk(SN, 3'd1));
    endtask

    task automatic terminal(input logic [2:0] t, input int k);
        for (int i = 0; i < k; i++) begin
            rand_in();
            start = 1'b1;
            push(mk(SN, t));
        end
    endtask

    // t: 0 retired, 2/3/4 terminal stat, 7 reset during MEM
    task automatic run_instr(input int ic, input bit iv, input bit ierr,
                             input bit c, input int n, input bit derr,
                             input int rm, output int t);
        exp_t e;
        t = 0;
        rand_in();
        icode       = 4'(ic);
        instr_valid = iv;
        imem_error  = ierr;
        push(mk(SF, 3'd1));
        if (ierr)    begin t = 3; return; end
        if (!iv)     begin t = 4; return; end
        if (ic == 0) begin t = 2; return; end
        rand_in();
        push(mk(SD, 3'd1));
        rand_in();
        cnd  = c;
        e    = mk(SE, 3'd1);
        e.cc = (ic == 6);
        push(e);
        if (ic inside {4, 5, 8, 9, 10, 11}) begin
            for (int i = 1; i <= n; i++) begin
                rand_in();
                mem_ready = (i == n);
                if (i == n) dmem_error = derr;
                if (i == rm) begin
                    rst   = 1'b1;
                    m_cyc = 0;
                    m_ret = 0;
                    #1;
                    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
                    chk("rst_stage", {26'd0, stage}, 32'd0);
                    chk("rst_stat", {29'd0, stat}, 32'd1);
                    chk("rst_busy", {31'd0, busy}, 32'd0);
                    push(mk(SN, 3'd1));
                    t = 7;
                    return;
                end
                e     = mk(SM, 3'd1);
                e.req = 1'b1;
                e.wr  = (ic inside {4, 8, 10});
                push(e);
            end
            if (derr) begin t = 3; return; end
        end
        rand_in();
        e     = mk(SW, 3'd1);
        e.rfe = (ic inside {3, 6, 8, 9, 10, 11}) || (ic == 2 && c);
        e.rfm = (ic inside {5, 11});
        push(e);
        rand_in();
        e     = mk(SP, 3'd1);
        e.pcw = 1'b1;
        push(e);
    endtask

    initial begin
        int t;
        int b0, b1, b2, b3;
        rst = 1'b0;
        rand_in();
        start = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_stage", {26'd0, stage}, 32'd0);
        chk("reset_stat", {29'd0, stat}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_cyc", cycle_cnt, 32'd0);
        chk("reset_ret", retired_cnt, 32'd0);

        begin_run();
        b0 = mon_pc; b1 = mon_rfe; b2 = mon_busy;
        run_instr(3, 1, 0, 0, 1, 0, 0, t);
        chk("irmov_pc", mon_pc - b0, 1);
        chk("irmov_rfe", mon_rfe - b1, 1);
        chk("irmov_cycles", mon_busy - b2, 5);
`ifdef Y86_SEQ_CTRL_PERF_EN
        chk("irmov_retired", retired_cnt, 32'd1);
`endif

        b1 = mon_rfe;
        run_instr(2, 1, 0, 0, 1, 0, 0, t);
        chk("cmov_nc_rfe", mon_rfe - b1, 0);
        run_instr(2, 1, 0, 1, 1, 0, 0, t);
        chk("cmov_c_rfe", mon_rfe - b1, 1);

        b0 = mon_req; b1 = mon_rfm; b2 = mon_busy;
        run_instr(5, 1, 0, 0, 3, 0, 0, t);
        chk("mrmov_req", mon_req - b0, 3);
        chk("mrmov_rfm", mon_rfm - b1, 1);
        chk("mrmov_cycles", mon_busy - b2, 8);

        b0 = mon_both;
        run_instr(11, 1, 0, 0, 1, 0, 0, t);
        chk("pop_both", mon_both - b0, 1);

        b0 = mon_pc;
        run_instr(0, 1, 0, 0, 1, 0, 0, t);
        terminal(3'(t), 4);
        chk("halt_stat", {29'd0, stat}, 32'd2);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        chk("halt_pc", mon_pc - b0, 0);

        do_reset();
        begin_run();
        run_instr(6, 1, 1, 0, 1, 0, 0, t);
        terminal(3'(t), 2);
        chk("imem_stat", {29'd0, stat}, 32'd3);

        do_reset();
        begin_run();
        run_instr(6, 0, 0, 0, 1, 0, 0, t);
        terminal(3'(t), 2);
        chk("ins_stat", {29'd0, stat}, 32'd4);

        do_reset();
        begin_run();
        b0 = mon_w; b1 = mon_pc;
        run_instr(4, 1, 0, 0, 2, 1, 0, t);
        terminal(3'(t), 3);
        chk("dmem_stat", {29'd0, stat}, 32'd3);
        chk("dmem_no_wb", mon_w - b0, 0);
        chk("dmem_no_pc", mon_pc - b1, 0);

        do_reset();
        begin_run();
        run_instr(4, 1, 0, 0, 5, 0, 2, t);
        release_reset();
        begin_run();

        for (int k = 0; k < 300; k++) begin
            int  ic, n, rm;
            bit  iv, ierr, c, derr;
            ic = $urandom_range(0, 11);
            if (ic == 0 && $urandom_range(0, 2) != 0) ic = 1;
            iv   = ($urandom_range(0, 19) != 0);
            ierr = ($urandom_range(0, 24) == 0);
            c    = 1'($urandom);
            n    = $urandom_range(1, 4);
            derr = ($urandom_range(0, 14) == 0);
            rm   = ($urandom_range(0, 19) == 0) ? $urandom_range(1, n) : 0;
            run_instr(ic, iv, ierr, c, n, derr, rm, t);
            if (t == 7) begin
                release_reset();
                begin_run();
            end else if (t != 0) begin
                terminal(3'(t), $urandom_range(1, 4));
                do_reset();
                begin_run();
            end
        end

        rand_in();
        push(mk(SF, 3'd1));
        @(posedge clk);
        #1;
        chk("queue_drain", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
